// File: rtl/instr_encoder.sv
// instr_encoder: packs RV32I fields + immediate into a machine word,
// buffers it in a small FIFO and stamps it with a running emit address.
//
// Ports:
//   clk, rst          clock, async active-high reset
//   in_valid/ready    request handshake
//   in_type           0=R 1=I 2=S 3=B 4=U 5=J (6,7 undefined)
//   in_opcode..in_imm decoded fields and full-value immediate
//   addr_load/value   load the emit address (low two bits forced to 0)
//   out_valid/ready   FIFO head handshake
//   out_instr/addr    encoded word and its emit address
//   out_err           immediate failed range/alignment check
//   err_count         saturating count of failing accepted requests
//
// Option: INSTR_ENC_STRICT_EN drops failing requests instead of queueing.
module instr_encoder #(
  parameter int          DEPTH      = 2,
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_type,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  input  logic        addr_load,
  input  logic [31:0] addr_value,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        out_err,
  output logic [7:0]  err_count
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [2:0] R_TYPE = 3'd0;
  localparam logic [2:0] I_TYPE = 3'd1;
  localparam logic [2:0] S_TYPE = 3'd2;
  localparam logic [2:0] B_TYPE = 3'd3;
  localparam logic [2:0] U_TYPE = 3'd4;
  localparam logic [2:0] J_TYPE = 3'd5;

  logic [31:0] word;
  logic        bad;
  logic        acc;
  logic        push;
  logic        pop;
  logic        full;
  logic        empty;
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic [31:0] cnt;
  logic [31:0] load_addr;
  logic [31:0] wa;

  logic [31:0] mem_instr [DEPTH];
  logic [31:0] mem_addr  [DEPTH];

  // Sign-extension checks: the high bits must all be copies of the
  // top bit the field can hold.
  logic fits12;
  logic fits13;
  logic fits21;

  assign fits12 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign fits13 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
  assign fits21 = (&in_imm[31:20]) | ~(|in_imm[31:20]);

  always_comb begin
    word = '0;
    bad  = 1'b0;
    unique case (in_type)
      R_TYPE: begin
        word = {in_funct7, in_rs2, in_rs1,
                in_funct3, in_rd, in_opcode};
      end
      I_TYPE: begin
        word = {in_imm[11:0], in_rs1,
                in_funct3, in_rd, in_opcode};
        bad  = ~fits12;
      end
      S_TYPE: begin
        word = {in_imm[11:5], in_rs2, in_rs1,
                in_funct3, in_imm[4:0], in_opcode};
        bad  = ~fits12;
      end
      B_TYPE: begin
        word = {in_imm[12], in_imm[10:5], in_rs2,
                in_rs1, in_funct3, in_imm[4:1],
                in_imm[11], in_opcode};
        bad  = ~fits13 | in_imm[0];
      end
      U_TYPE: begin
        word = {in_imm[31:12], in_rd, in_opcode};
        bad  = |in_imm[11:0];
      end
      J_TYPE: begin
        word = {in_imm[20], in_imm[10:1], in_imm[11],
                in_imm[19:12], in_rd, in_opcode};
        bad  = ~fits21 | in_imm[0];
      end
      default: begin
        word = '0;
        bad  = 1'b1;
      end
    endcase
  end

  assign empty    = (wptr == rptr);
  assign full     = (wptr[AW] != rptr[AW]) &&
                    (wptr[AW-1:0] == rptr[AW-1:0]);
  assign in_ready = ~full | out_ready;
  assign acc      = in_valid & in_ready;
  assign pop      = ~empty & out_ready;

`ifdef INSTR_ENC_STRICT_EN
  assign push = acc & ~bad;
`else
  assign push = acc;
`endif

  assign load_addr = addr_value & 32'hFFFF_FFFC;
  assign wa        = addr_load ? load_addr : cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      cnt       <= RESET_ADDR;
      err_count <= '0;
    end else begin
      if (push)
        wptr <= wptr + 1'b1;
      if (pop)
        rptr <= rptr + 1'b1;
      // A dropped request still honours a same-cycle load.
      if (push)
        cnt <= wa + 32'd4;
      else if (addr_load)
        cnt <= load_addr;
      if (acc && bad && err_count != 8'hFF)
        err_count <= err_count + 8'd1;
    end
  end

  // Storage needs no reset: the head is masked while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[wptr[AW-1:0]] <= word;
      mem_addr[wptr[AW-1:0]]  <= wa;
    end
  end

  assign out_valid = ~empty;
  assign out_instr = empty ? '0 : mem_instr[rptr[AW-1:0]];
  assign out_addr  = empty ? '0 : mem_addr[rptr[AW-1:0]];

`ifdef INSTR_ENC_STRICT_EN
  assign out_err = 1'b0;
`else
  logic mem_err [DEPTH];

  always_ff @(posedge clk) begin
    if (push)
      mem_err[wptr[AW-1:0]] <= bad;
  end

  assign out_err = ~empty & mem_err[rptr[AW-1:0]];
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed-vector bench for instr_encoder.
// Expected words are hand-encoded constants.
module tb_instr_encoder;

  localparam logic [2:0] RT = 3'd0;
  localparam logic [2:0] IT = 3'd1;
  localparam logic [2:0] ST = 3'd2;
  localparam logic [2:0] BT = 3'd3;
  localparam logic [2:0] UT = 3'd4;
  localparam logic [2:0] JT = 3'd5;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_type;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        addr_load;
  logic [31:0] addr_value;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        out_err;
  logic [7:0]  err_count;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  instr_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_type   (in_type),
    .in_opcode (in_opcode),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_imm    (in_imm),
    .addr_load (addr_load),
    .addr_value(addr_value),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_addr  (out_addr),
    .out_err   (out_err),
    .err_count (err_count)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setf(input logic [2:0]  t,
                      input logic [6:0]  op,
                      input logic [4:0]  rd,
                      input logic [4:0]  r1,
                      input logic [4:0]  r2,
                      input logic [2:0]  f3,
                      input logic [6:0]  f7,
                      input logic [31:0] imm);
    in_type   = t;
    in_opcode = op;
    in_rd     = rd;
    in_rs1    = r1;
    in_rs2    = r2;
    in_funct3 = f3;
    in_funct7 = f7;
    in_imm    = imm;
  endtask

  task automatic push(input logic [2:0]  t,
                      input logic [6:0]  op,
                      input logic [4:0]  rd,
                      input logic [4:0]  r1,
                      input logic [4:0]  r2,
                      input logic [2:0]  f3,
                      input logic [6:0]  f7,
                      input logic [31:0] imm);
    setf(t, op, rd, r1, r2, f3, f7, imm);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pop_chk(input string tag,
                         input logic [31:0] ins,
                         input logic [31:0] adr,
                         input logic er);
    chk({tag, ".v"}, 32'(out_valid), 32'd1);
    chk({tag, ".i"}, out_instr, ins);
    chk({tag, ".a"}, out_addr, adr);
    chk({tag, ".e"}, 32'(out_err), 32'(er));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    addr_load  = 1'b0;
    addr_value = '0;
    setf(RT, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    #2;
    chk("rst.v", 32'(out_valid), 32'd0);
    chk("rst.i", out_instr, 32'd0);
    chk("rst.a", out_addr, 32'd0);
    chk("rst.e", 32'(out_err), 32'd0);
    chk("rst.c", 32'(err_count), 32'd0);
    #1;
    rst = 1'b0;
    tick();
    chk("rst.rdy", 32'(in_ready), 32'd1);

    // addi x1, x0, -1 : one-cycle latency
    push(IT, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
    pop_chk("addi", 32'hFFF0_0093, 32'h0, 1'b0);
    chk("addi.empty", 32'(out_valid), 32'd0);

    // Branch / jump and the remaining formats
    do_reset();
    push(BT, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFF8);
    push(JT, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    pop_chk("beq", 32'hFE20_8CE3, 32'h0, 1'b0);
    pop_chk("jal", 32'h0010_006F, 32'h4, 1'b0);
    push(ST, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    push(RT, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'hFFFF_FFFF);
    pop_chk("sw", 32'h0020_A423, 32'h8, 1'b0);
    pop_chk("add", 32'h0020_81B3, 32'hC, 1'b0);
    push(RT, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0);
    push(UT, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
    pop_chk("sub", 32'h4020_81B3, 32'h10, 1'b0);
    pop_chk("lui", 32'h1234_50B7, 32'h14, 1'b0);
    push(BT, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4094);
    push(JT, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFF0_0000);
    pop_chk("bmax", 32'h7E00_0FE3, 32'h18, 1'b0);
    pop_chk("jmin", 32'h8000_006F, 32'h1C, 1'b0);
    chk("fmt.c", 32'(err_count), 32'd0);

    // Range / alignment failures
    do_reset();
    push(IT, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    push(BT, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
    chk("err.c2", 32'(err_count), 32'd2);
`ifdef INSTR_ENC_STRICT_EN
    chk("err.drop", 32'(out_valid), 32'd0);
    push(3'd7, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    chk("err.drop2", 32'(out_valid), 32'd0);
    chk("err.c3", 32'(err_count), 32'd3);
    push(IT, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    pop_chk("err.good", 32'h0050_0093, 32'h0, 1'b0);
`else
    pop_chk("err.i", 32'h8000_0093, 32'h0, 1'b1);
    pop_chk("err.b", 32'h0020_8163, 32'h4, 1'b1);
    push(3'd7, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    pop_chk("err.undef", 32'h0, 32'h8, 1'b1);
    chk("err.c3", 32'(err_count), 32'd3);
    push(IT, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    pop_chk("err.good", 32'h0050_0093, 32'hC, 1'b0);
`endif

    // Backpressure with DEPTH=2
    do_reset();
    push(IT, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    push(IT, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    setf(IT, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    in_valid = 1'b1;
    chk("bp.full", 32'(in_ready), 32'd0);
    tick();
    chk("bp.hold", 32'(in_ready), 32'd0);
    chk("bp.head", out_instr, 32'h0000_0093);
    out_ready = 1'b1;
    #1;
    chk("bp.rdy", 32'(in_ready), 32'd1);
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    pop_chk("bp.w2", 32'h0000_0113, 32'h4, 1'b0);
    pop_chk("bp.w3", 32'h0000_0193, 32'h8, 1'b0);
    chk("bp.empty", 32'(out_valid), 32'd0);

    // Address loading and wrap
    do_reset();
    addr_load  = 1'b1;
    addr_value = 32'h100;
    push(IT, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    addr_load = 1'b0;
    push(IT, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    pop_chk("ld.w1", 32'h0000_0093, 32'h100, 1'b0);
    pop_chk("ld.w2", 32'h0000_0113, 32'h104, 1'b0);
    addr_load  = 1'b1;
    addr_value = 32'hFFFF_FFFF;
    tick();
    addr_load = 1'b0;
    chk("ld.idle", 32'(out_valid), 32'd0);
    push(IT, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    push(IT, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    pop_chk("wrap.w1", 32'h0000_0093, 32'hFFFF_FFFC, 1'b0);
    pop_chk("wrap.w2", 32'h0000_0113, 32'h0, 1'b0);

    // Reset while the FIFO holds two words
    do_reset();
    push(UT, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h123);
`ifndef INSTR_ENC_STRICT_EN
    pop_chk("u.err", 32'h0000_02B7, 32'h0, 1'b1);
`endif
    chk("mid.c", 32'(err_count), 32'd1);
    push(IT, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    push(IT, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    chk("mid.v", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid.rv", 32'(out_valid), 32'd0);
    chk("mid.rc", 32'(err_count), 32'd0);
    chk("mid.ri", out_instr, 32'd0);
    rst = 1'b0;
    push(IT, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    pop_chk("mid.w", 32'h0000_0193, 32'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Packs decoded instruction fields and a 32-bit signed/aligned immediate into a 32-bit RV32I instruction word; the inverse of immediate extraction.
- Used by the toy-scheme code emitter to stream machine words into program memory.
- Valid/ready input, buffered valid/ready output FIFO, running emit-address counter, and per-word immediate range/alignment checking.

Parameters:
- DEPTH, 2, output FIFO entries (power of two, >=2)
- RESET_ADDR, 32'h0000_0000, emit address after reset

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  request valid
- in_ready  output  1  request accepted when in_valid & in_ready
- in_type  input  3  shared instruction-type code: R_TYPE, I_TYPE, S_TYPE, B_TYPE, U_TYPE or J_TYPE
- in_opcode  input  7  opcode[6:0]
- in_rd  input  5  rd
- in_rs1  input  5  rs1
- in_rs2  input  5  rs2
- in_funct3  input  3  funct3
- in_funct7  input  7  funct7 (R_TYPE only)
- in_imm  input  32  full-value immediate, byte offset for B/J
- addr_load  input  1  load emit address
- addr_value  input  32  new emit address, word aligned
- out_valid  output  1  FIFO head valid
- out_ready  input  1  consumer pops head when out_valid & out_ready
- out_instr  output  32  encoded word
- out_addr  output  32  address assigned to word
- out_err  output  1  immediate failed range/alignment check
- err_count  output  8  saturating count of failing accepted requests

Behaviour:
- Reset, async: FIFO empty, out_valid=0, out_instr/out_addr/out_err=0, err_count=0, addr counter=RESET_ADDR. in_ready=1 once reset deasserts.
- in_ready = !full OR (full & out_ready), same-cycle pop frees a slot.
- Latency: a word accepted at edge N is visible at the head by N+1 if the FIFO was empty. Order is strictly FIFO.
- Outputs are driven from registers and the FIFO only; no combinational path from in_* to out_*.
- Encoding:
  - R: {funct7, rs2, rs1, funct3, rd, opcode}
  - I: {imm[11:0], rs1, funct3, rd, opcode}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
  - U: {imm[31:12], rd, opcode}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}
  - Undefined type: word 0, err=1.
- Range checks (err=1 if violated):
  - I/S: -2048..2047
  - B: -4096..4094, imm[0]=0
  - U: imm[11:0]=0
  - J: -1048576..1048574, imm[0]=0
  - R: in_imm ignored, never err
- Address counter:
  - Each accepted word takes the current counter value; counter += 4 (wraps mod 2^32).
  - addr_load without accept: counter = addr_value.
  - addr_load with same-cycle accept: the word takes addr_value and counter = addr_value+4.
  - addr_value[1:0] is forced to 0.
- err_count increments on each accepted erroneous request and saturates at 255.
- Simultaneous push and pop when full: both occur, occupancy unchanged. Pop on empty is ignored.
- Reset mid-stream drops all FIFO contents immediately.

Optional Feature:
- Macro INSTR_ENC_STRICT_EN.
- Defined: erroneous requests are still accepted (in_ready unaffected) but not enqueued; the counter does not advance; err_count increments; out_err is tied to 0.
- Undefined: erroneous words are enqueued with the truncated immediate fields, out_err=1, and the counter advances.

Test Plan:
- I_TYPE, opcode 7'h13, rd 1, rs1 0, funct3 0, imm -1 after reset -> out_instr 32'hFFF00093, out_addr 0, out_err 0, one cycle latency.
- B_TYPE, opcode 7'h63, rs1 1, rs2 2, funct3 0, imm -8, then J_TYPE, opcode 7'h6F, rd 0, imm 2048 -> 32'hFE208CE3 then 32'h0010006F; addresses 0 and 4.
- I_TYPE imm 2048, then B_TYPE imm 3:
  - Default: two words with out_err=1, err_count=2.
  - INSTR_ENC_STRICT_EN: nothing emitted, err_count=2, next good word gets addr 0.
- out_ready held 0, 3 requests with DEPTH 2 -> in_ready drops after 2. Raise out_ready with in_valid held -> third accepted in the same cycle as the pop; order preserved.
- addr_load 32'h100 with a same-cycle accept -> word addr 32'h100, next word 32'h104. Load 32'hFFFFFFFC then 2 accepts -> addrs FFFFFFFC, 0.
- Assert rst while the FIFO holds 2 words -> out_valid=0 at once, err_count=0, next word addr RESET_ADDR.
